// File: rtl/mc_maindec_ext_if.sv
// mc_maindec_ext_if: opcode/handshake inputs and datapath control outputs of the multicycle main decoder.
interface mc_maindec_ext_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite, memwrite, irwrite, regwrite;
    logic       alusrca, branch, branch_ne, iord, imm_zext;
    logic       mem_req, exception;
    logic [1:0] memtoreg, regdst, alusrcb, pcsrc;
    logic [2:0] aluop;
    logic [3:0] state;
    modport master (
        input  op, mem_ready,
        output pcwrite, memwrite, irwrite, regwrite, alusrca, branch, branch_ne, iord, imm_zext,
        output mem_req, exception, memtoreg, regdst, alusrcb, pcsrc, aluop, state
    );
    modport slave (
        output op, mem_ready,
        input  pcwrite, memwrite, irwrite, regwrite, alusrca, branch, branch_ne, iord, imm_zext,
        input  mem_req, exception, memtoreg, regdst, alusrcb, pcsrc, aluop, state
    );
endinterface

// File: rtl/mc_maindec_ext.sv
// mc_maindec_ext: multicycle MIPS main control FSM with BNE/JAL/immediate ALU ops, memory wait and illegal-opcode trap.
module mc_maindec_ext #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit IMM_EXT     = 1'b1,
    parameter bit EXC_EN      = 1'b1
) (
    input logic clk,
    input logic reset_n,
    mc_maindec_ext_if.master bus
);
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011;
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEQEX = 4'd8, IEX = 4'd9,
        IWB = 4'd10, JEX = 4'd11, BNEEX = 4'd12, JALEX = 4'd13, EXC = 4'd14
    } state_t;
    state_t st, nx;
    logic rdy, is_imm;
    assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
    assign is_imm = bus.op == OP_ADDI ||
                    (IMM_EXT && (bus.op == OP_ANDI || bus.op == OP_ORI || bus.op == OP_SLTI));
    always_comb begin
        nx = FETCH;
        case (st)
            FETCH:   nx = rdy ? DECODE : FETCH;
            DECODE:  nx = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                          bus.op == OP_RTYPE ? RTYPEEX :
                          bus.op == OP_BEQ   ? BEQEX :
                          bus.op == OP_BNE   ? BNEEX :
                          is_imm             ? IEX :
                          bus.op == OP_J     ? JEX :
                          bus.op == OP_JAL   ? JALEX :
                          EXC_EN             ? EXC : FETCH;
            MEMADR:  nx = bus.op == OP_SW ? MEMWR : MEMRD;
            MEMRD:   nx = rdy ? MEMWB : MEMRD;
            MEMWR:   nx = rdy ? FETCH : MEMWR;
            RTYPEEX: nx = RTYPEWB;
            IEX:     nx = IWB;
            default: nx = FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st <= FETCH;
        else st <= nx;
    end
    // Write strobes in memory states are gated by rdy so a stalled access writes only once.
    always_comb begin
        bus.pcwrite = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca = 1'b0;
        bus.branch = 1'b0;
        bus.branch_ne = 1'b0;
        bus.iord = 1'b0;
        bus.imm_zext = 1'b0;
        bus.mem_req = 1'b0;
        bus.exception = 1'b0;
        bus.memtoreg = 2'b00;
        bus.regdst = 2'b00;
        bus.alusrcb = 2'b00;
        bus.pcsrc = 2'b00;
        bus.aluop = 3'b000;
        bus.state = st;
        case (st)
            FETCH: begin
                bus.mem_req = 1'b1;
                bus.alusrcb = 2'b01;
                bus.pcwrite = rdy;
                bus.irwrite = rdy;
            end
            DECODE: bus.alusrcb = 2'b11;
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord = 1'b1;
            end
            MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 2'b01;
            end
            MEMWR: begin
                bus.mem_req = 1'b1;
                bus.iord = 1'b1;
                bus.memwrite = rdy;
            end
            RTYPEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop = 3'b010;
            end
            RTYPEWB: begin
                bus.regwrite = 1'b1;
                bus.regdst = 2'b01;
            end
            BEQEX, BNEEX: begin
                bus.alusrca = 1'b1;
                bus.branch = st == BEQEX;
                bus.branch_ne = st == BNEEX;
                bus.pcsrc = 2'b01;
                bus.aluop = 3'b001;
            end
            IEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.aluop = bus.op == OP_ANDI ? 3'b011 : bus.op == OP_ORI ? 3'b100 :
                            bus.op == OP_SLTI ? 3'b101 : 3'b000;
                bus.imm_zext = bus.op == OP_ANDI || bus.op == OP_ORI;
            end
            IWB: bus.regwrite = 1'b1;
            JEX: begin
                bus.pcwrite = 1'b1;
                bus.pcsrc = 2'b10;
            end
            JALEX: begin
                bus.pcwrite = 1'b1;
                bus.pcsrc = 2'b10;
                bus.regwrite = 1'b1;
                bus.regdst = 2'b10;
                bus.memtoreg = 2'b10;
            end
            EXC: begin
                bus.pcwrite = 1'b1;
                bus.pcsrc = 2'b11;
                bus.exception = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mc_maindec_ext.sv
// tb_mc_maindec_ext: directed scoreboard bench for mc_maindec_ext across its parameter variants.
module tb_mc_maindec_ext;
    typedef struct packed {
        logic [3:0] st;
        logic pw, mw, iw, rw, asa, br, bne, iord, zx, mrq, exc;
        logic [1:0] m2r, rd, asb, pcs;
        logic [2:0] aop;
    } ctl_t;
    typedef struct {
        int    sel;
        string tag;
        ctl_t  e;
    } item_t;

    logic clk = 1'b0, reset_n = 1'b0, mem_ready = 1'b0;
    logic [5:0] op = 6'b0;
    int checks = 0, errors = 0;
    item_t sb[$];
    ctl_t o[4];

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] SLTI = 6'b001010, J = 6'b000010, JAL = 6'b000011, ILL = 6'b111111;

    always #5 clk = ~clk;

    mc_maindec_ext_if b0 ();
    mc_maindec_ext_if b1 ();
    mc_maindec_ext_if b2 ();
    mc_maindec_ext_if b3 ();
    mc_maindec_ext dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    mc_maindec_ext #(.MEM_WAIT_EN(1'b0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    mc_maindec_ext #(.IMM_EXT(1'b0)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));
    mc_maindec_ext #(.EXC_EN(1'b0)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3));

    assign b0.op = op;
    assign b1.op = op;
    assign b2.op = op;
    assign b3.op = op;
    assign b0.mem_ready = mem_ready;
    assign b1.mem_ready = mem_ready;
    assign b2.mem_ready = mem_ready;
    assign b3.mem_ready = mem_ready;
    assign o[0] = {b0.state, b0.pcwrite, b0.memwrite, b0.irwrite, b0.regwrite, b0.alusrca, b0.branch, b0.branch_ne,
                   b0.iord, b0.imm_zext, b0.mem_req, b0.exception, b0.memtoreg, b0.regdst, b0.alusrcb, b0.pcsrc, b0.aluop};
    assign o[1] = {b1.state, b1.pcwrite, b1.memwrite, b1.irwrite, b1.regwrite, b1.alusrca, b1.branch, b1.branch_ne,
                   b1.iord, b1.imm_zext, b1.mem_req, b1.exception, b1.memtoreg, b1.regdst, b1.alusrcb, b1.pcsrc, b1.aluop};
    assign o[2] = {b2.state, b2.pcwrite, b2.memwrite, b2.irwrite, b2.regwrite, b2.alusrca, b2.branch, b2.branch_ne,
                   b2.iord, b2.imm_zext, b2.mem_req, b2.exception, b2.memtoreg, b2.regdst, b2.alusrcb, b2.pcsrc, b2.aluop};
    assign o[3] = {b3.state, b3.pcwrite, b3.memwrite, b3.irwrite, b3.regwrite, b3.alusrca, b3.branch, b3.branch_ne,
                   b3.iord, b3.imm_zext, b3.mem_req, b3.exception, b3.memtoreg, b3.regdst, b3.alusrcb, b3.pcsrc, b3.aluop};

    function automatic ctl_t mk(input int s, input int pw, input int mw, input int iw, input int rw, input int asa,
                                input int br, input int bne, input int iord, input int zx, input int mrq, input int exc,
                                input int m2r, input int rd, input int asb, input int pcs, input int aop);
        return {4'(s), 1'(pw), 1'(mw), 1'(iw), 1'(rw), 1'(asa), 1'(br), 1'(bne), 1'(iord), 1'(zx), 1'(mrq), 1'(exc),
                2'(m2r), 2'(rd), 2'(asb), 2'(pcs), 3'(aop)};
    endfunction

    //                                    st pw mw iw rw as br bn io zx mq ex m2 rd sb pc op
    function automatic ctl_t e_fetch(input int r); return mk(0, r, 0, r, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0); endfunction
    function automatic ctl_t e_dec();    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0); endfunction
    function automatic ctl_t e_madr();   return mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0); endfunction
    function automatic ctl_t e_mrd();    return mk(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); endfunction
    function automatic ctl_t e_mwb();    return mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); endfunction
    function automatic ctl_t e_mwr(input int r); return mk(5, 0, r, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); endfunction
    function automatic ctl_t e_rex();    return mk(6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2); endfunction
    function automatic ctl_t e_rwb();    return mk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); endfunction
    function automatic ctl_t e_beq();    return mk(8, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); endfunction
    function automatic ctl_t e_iex(input int a, input int z); return mk(9, 0, 0, 0, 0, 1, 0, 0, 0, z, 0, 0, 0, 0, 2, 0, a); endfunction
    function automatic ctl_t e_iwb();    return mk(10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic ctl_t e_jex();    return mk(11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0); endfunction
    function automatic ctl_t e_bne();    return mk(12, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1); endfunction
    function automatic ctl_t e_jal();    return mk(13, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 2, 0); endfunction
    function automatic ctl_t e_exc();    return mk(14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0); endfunction

    task automatic push(input int sel, input string tag, input ctl_t e);
        item_t it;
        it.sel = sel;
        it.tag = tag;
        it.e = e;
        sb.push_back(it);
    endtask

    task automatic chk();
        item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got no entry, required one");
            return;
        end
        it = sb.pop_front();
        assert (o[it.sel] === it.e) else begin
            errors++;
            $error("FAIL %s (dut%0d): got %h required %h", it.tag, it.sel, o[it.sel], it.e);
        end
    endtask

    task automatic step(input int sel, input string tag, input ctl_t e);
        push(sel, tag, e);
        @(negedge clk);
        chk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2;
        push(0, "reset_fetch", e_fetch(0));
        chk();
        do_reset();
        // LW with memory stalls in FETCH and MEMRD
        op = LW;
        mem_ready = 1'b0;
        step(0, "lw_fetch_wait1", e_fetch(0));
        step(0, "lw_fetch_wait2", e_fetch(0));
        step(0, "lw_fetch_wait3", e_fetch(0));
        mem_ready = 1'b1;
        step(0, "lw_fetch_done", e_fetch(1));
        mem_ready = 1'b0;
        step(0, "lw_decode", e_dec());
        step(0, "lw_memadr", e_madr());
        step(0, "lw_memrd_wait1", e_mrd());
        step(0, "lw_memrd_wait2", e_mrd());
        mem_ready = 1'b1;
        step(0, "lw_memrd_done", e_mrd());
        step(0, "lw_memwb", e_mwb());
        // SW: completes, then stalls once to show memwrite is not repeated
        op = SW;
        step(0, "sw_fetch", e_fetch(1));
        step(0, "sw_decode", e_dec());
        step(0, "sw_memadr", e_madr());
        step(0, "sw_memwr", e_mwr(1));
        step(0, "sw2_fetch", e_fetch(1));
        step(0, "sw2_decode", e_dec());
        step(0, "sw2_memadr", e_madr());
        mem_ready = 1'b0;
        step(0, "sw2_memwr_wait", e_mwr(0));
        mem_ready = 1'b1;
        step(0, "sw2_memwr_done", e_mwr(1));
        op = RT;
        step(0, "rt_fetch", e_fetch(1));
        step(0, "rt_decode", e_dec());
        step(0, "rt_ex", e_rex());
        step(0, "rt_wb", e_rwb());
        op = BEQ;
        step(0, "beq_fetch", e_fetch(1));
        step(0, "beq_decode", e_dec());
        step(0, "beq_ex", e_beq());
        op = BNE;
        step(0, "bne_fetch", e_fetch(1));
        step(0, "bne_decode", e_dec());
        step(0, "bne_ex", e_bne());
        op = ANDI;
        step(0, "andi_fetch", e_fetch(1));
        step(0, "andi_decode", e_dec());
        step(0, "andi_iex", e_iex(3, 1));
        step(0, "andi_iwb", e_iwb());
        op = ORI;
        step(0, "ori_fetch", e_fetch(1));
        step(0, "ori_decode", e_dec());
        step(0, "ori_iex", e_iex(4, 1));
        step(0, "ori_iwb", e_iwb());
        op = SLTI;
        step(0, "slti_fetch", e_fetch(1));
        step(0, "slti_decode", e_dec());
        step(0, "slti_iex", e_iex(5, 0));
        step(0, "slti_iwb", e_iwb());
        op = ADDI;
        step(0, "addi_fetch", e_fetch(1));
        step(0, "addi_decode", e_dec());
        step(0, "addi_iex", e_iex(0, 0));
        step(0, "addi_iwb", e_iwb());
        op = J;
        step(0, "j_fetch", e_fetch(1));
        step(0, "j_decode", e_dec());
        step(0, "j_ex", e_jex());
        op = JAL;
        step(0, "jal_fetch", e_fetch(1));
        step(0, "jal_decode", e_dec());
        step(0, "jal_ex", e_jal());
        op = ILL;
        step(0, "ill_fetch", e_fetch(1));
        step(0, "ill_decode", e_dec());
        step(0, "ill_exc", e_exc());
        step(0, "ill_back_fetch", e_fetch(1));
        // No memory wait: mem_ready low is ignored; async reset lands mid-MEMRD
        do_reset();
        op = LW;
        mem_ready = 1'b0;
        step(1, "nw_fetch", e_fetch(1));
        step(1, "nw_decode", e_dec());
        step(1, "nw_memadr", e_madr());
        push(1, "nw_memrd", e_mrd());
        @(negedge clk);
        chk();
        reset_n = 1'b0;
        #1;
        push(1, "nw_async_reset", e_fetch(1));
        chk();
        @(posedge clk);
        #1;
        push(1, "nw_reset_held", e_fetch(1));
        chk();
        reset_n = 1'b1;
        step(1, "nw_after_reset_fetch", e_fetch(1));
        step(1, "nw_after_reset_decode", e_dec());
        // IMM_EXT=0: ANDI is illegal
        do_reset();
        mem_ready = 1'b1;
        op = ANDI;
        step(2, "noimm_fetch", e_fetch(1));
        step(2, "noimm_decode", e_dec());
        step(2, "noimm_andi_exc", e_exc());
        step(2, "noimm_back_fetch", e_fetch(1));
        // EXC_EN=0: illegal opcode returns to FETCH without writes
        do_reset();
        op = ILL;
        step(3, "noexc_fetch", e_fetch(1));
        step(3, "noexc_decode", e_dec());
        mem_ready = 1'b0;
        step(3, "noexc_back_fetch", e_fetch(0));
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
